lfsr_rr_server: RTL and testbench
=================================

Name: lfsr_rr_server

Overview:
Round-robin server that shares one multi-word LFSR generator among NREQ requesters. Each requester asks for a burst of blocks. A block is POLY consecutive WIDTH-bit LFSR states, produced in one cycle by a chain of POLY lfsr step instances. The block owns the generator state register, advances it only on output handshakes, and handles runtime reseeding. It sits between the pseudo-random generator datapath and consumers such as test-pattern or scrambler engines.

Parameters:
WIDTH, 16, bits per LFSR word
POLY, 4, LFSR words per output block (chain depth)
NREQ, 4, number of requesters (at least 2)
LENW, 8, width of burst-length field
SEED, all ones (WIDTH bits), generator state after reset

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
req_valid  in  NREQ  per-requester burst request
req_len  in  NREQ x LENW  burst length in blocks; 0 is treated as 1
req_ready  out  NREQ  one-hot, single-cycle accept pulse
seed_load  in  1  request to load a new seed
seed_value  in  WIDTH  seed to load
out_valid  out  1  output block valid
out_ready  in  1  consumer ready
out_data  out  POLY x WIDTH  packed [POLY-1:0][WIDTH-1:0]; word i = lfsr^i(state)
out_id  out  clog2(NREQ)  index of the requester being served
out_last  out  1  final block of the burst
busy  out  1  a burst is in progress (RUN state)

Behaviour:
- FSM states: IDLE, RUN. All outputs are registered.
- Reset (reset_n = 0 at a clock edge):
  - state register = SEED; FSM = IDLE; RR pointer = 0; seed_pend = 0.
  - req_ready, out_valid, out_last, busy = 0; out_id = 0; out_data = 0.
  - Any burst in flight is abandoned with no completion beat.
- IDLE:
  - If seed_pend is set, apply the pending seed this cycle and make no grant.
  - Otherwise, if any req_valid is high, grant the first requesting index at or after the RR pointer, wrapping modulo NREQ.
  - On a grant: pulse req_ready[g] for 1 cycle; capture len (0 becomes 1); set out_id = g; set RR pointer = (g+1) mod NREQ; go to RUN.
- RUN:
  - out_valid = 1 starting the cycle after the grant.
  - out_data word i = lfsr applied i times to the state register (word 0 = state).
  - out_last = 1 when beat count = len-1.
  - On out_valid & out_ready:
    - state register = lfsr^POLY(state), i.e. the chain output.
    - Beat count increments.
    - If the beat was last: out_valid = 0 and the FSM returns to IDLE the next cycle. There is one idle cycle between bursts, with no back-to-back grant.
  - Without ready, out_data, out_id and out_last hold stable. The state register must not advance.
- Seeding:
  - seed_load in IDLE with no pending seed: state register = seed_value next cycle. This takes priority over a grant in the same cycle, so the grant is delayed by 1 cycle.
  - seed_load in RUN: capture seed_value into the pending register and set seed_pend. The seed is applied in the first IDLE cycle. A later seed_load overwrites the pending value (last wins).
  - A seed value of 0 (lockup) is replaced by all ones.
- req_valid is sampled only in IDLE. Deassertion during RUN has no effect on the current burst.
- Length rules: bursts run 1..2^LENW-1 blocks. The counter is LENW bits and never wraps past len.

Decomposition:
- Package lfsr_rr_pkg:
  - FSM state enum (IDLE, RUN).
  - Function for ID width, clog2(NREQ).
  - Constant for the lockup substitute (all ones).
- Sub-module rr_arbiter:
  - Combinational round-robin pick, parameter NREQ.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
- The generator chain is POLY instances of the existing lfsr step module, driven from the state register.

Test Plan:
- Reset, then req_valid[2] = 1 with len = 3 and out_ready = 1:
  - req_ready[2] pulses 1 cycle after reset release.
  - 3 beats follow with out_id = 2 and out_last on beat 3.
  - Beat 0 word 0 = SEED; each beat matches the golden model (state advances by lfsr^POLY per beat).
- All four requesters held valid with len = 1:
  - Grant order 0,1,2,3,0,... with exactly one idle cycle between bursts.
  - Then drop req 1: order becomes 2,3,0,2.
- Backpressure: len = 4 with out_ready toggled 1,0,0,1,...
  - out_data, out_id and out_last stable while ready is low.
  - Exactly 4 handshakes; the state register advances only 4 times.
- Seeding in IDLE and RUN:
  - seed_load = 16'h0001 in IDLE -> next burst word 0 = 16'h0001.
  - seed_load = 16'h0000 -> word 0 = 16'hFFFF.
  - seed_load 16'h1234 then 16'hABCD during RUN -> current burst unaffected; next burst starts from 16'hABCD.
- req_len = 0 -> a single beat with out_last = 1.
- req_len = 255 -> 255 beats, last flagged only on beat 255.
- Reset asserted mid-burst (beat 2 of 5):
  - Outputs 0 next cycle; FSM in IDLE; pointer 0.
  - The re-requested burst starts from SEED.

Source files
------------

// File: rtl/lfsr_rr_pkg.sv
// rtl/lfsr_rr_pkg.sv - shared types and constants for the round-robin LFSR server
// Contents: FSM state enum, requester-id width helper, lockup substitute, default taps.
package lfsr_rr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // Width of a requester index; never below one bit so a 1-requester build still has a port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // An XOR-feedback LFSR stalls forever at zero, so a zero seed is replaced by all ones.
  localparam logic [63:0] LOCKUP_SUB = '1;

  // x^16 + x^14 + x^13 + x^11 + 1 (maximal length), feedback from bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

endpackage

// File: rtl/lfsr_rr_server_if.sv
// rtl/lfsr_rr_server_if.sv - request, seed and output-block signals of the LFSR server
// master: the server (drives req_ready and the output block); slave: requesters/consumer.
interface lfsr_rr_server_if #(
  parameter int WIDTH = 16,
  parameter int POLY  = 4,
  parameter int NREQ  = 4,
  parameter int LENW  = 8
);
  localparam int IDW = lfsr_rr_pkg::id_width(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][LENW-1:0]  req_len;
  logic [NREQ-1:0]            req_ready;
  logic                       seed_load;
  logic [WIDTH-1:0]           seed_value;
  logic                       out_valid;
  logic                       out_ready;
  logic [POLY-1:0][WIDTH-1:0] out_data;
  logic [IDW-1:0]             out_id;
  logic                       out_last;
  logic                       busy;

  modport master (
    input  req_valid, req_len, seed_load, seed_value, out_ready,
    output req_ready, out_valid, out_data, out_id, out_last, busy
  );

  modport slave (
    output req_valid, req_len, seed_load, seed_value, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_last, busy
  );

endinterface

// File: rtl/lfsr_rr_server_rr_arbiter.sv
// rtl/lfsr_rr_server_rr_arbiter.sv - combinational round-robin pick
// Ports: req = request vector, ptr = first index to consider;
//        grant = one-hot winner, idx = winner index, any = some request was present.
module rr_arbiter
  import lfsr_rr_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int cand;

  // Scan NREQ positions starting at ptr, wrapping; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - one Fibonacci LFSR step (shift left, XOR of tapped bits into bit 0)
// Ports: din = current state, dout = state after one step.
module lfsr_step #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = '1
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = {din[WIDTH-2:0], ^(din & TAPS)};

endmodule

// File: rtl/lfsr_rr_server.sv
// rtl/lfsr_rr_server.sv - round-robin server sharing one multi-word LFSR among requesters
// Ports: clk, reset_n (sync, active low), bus (master modport: req_valid/req_len/req_ready,
//        seed_load/seed_value, out_valid/out_ready/out_data/out_id/out_last, busy).
module lfsr_rr_server
  import lfsr_rr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               POLY  = 4,
  parameter int               NREQ  = 4,
  parameter int               LENW  = 8,
  parameter logic [WIDTH-1:0] SEED  = '1,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_16)
) (
  input logic              clk,
  input logic              reset_n,
  lfsr_rr_server_if.master bus
);

  localparam int               IDW     = id_width(NREQ);
  localparam int               LW1     = LENW + 1;
  localparam logic [WIDTH-1:0] NONZERO = LOCKUP_SUB[WIDTH-1:0];

  fsm_t                       fsm_q, fsm_d;
  logic [WIDTH-1:0]           state_q, state_d;
  logic [IDW-1:0]             ptr_q, ptr_d;
  logic                       seed_pend_q, seed_pend_d;
  logic [WIDTH-1:0]           seed_val_q, seed_val_d;
  logic [LENW-1:0]            len_q, len_d;
  logic [LENW-1:0]            beat_q, beat_d;
  logic [NREQ-1:0]            req_ready_q, req_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic [IDW-1:0]             out_id_q, out_id_d;
  logic [POLY-1:0][WIDTH-1:0] out_data_q, out_data_d;
  logic                       busy_q, busy_d;

  logic [NREQ-1:0]            grant_oh;
  logic [IDW-1:0]             grant_idx;
  logic                       grant_any;
  logic [LENW-1:0]            len_sel, len_eff;
  logic [WIDTH-1:0]           seed_fixed;
  logic [WIDTH-1:0]           adv;
  logic [POLY-1:0][WIDTH-1:0] words;
  logic                       fire;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant_oh),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign seed_fixed = (bus.seed_value == '0) ? NONZERO : bus.seed_value;
  assign len_sel    = bus.req_len[grant_idx];
  assign len_eff    = (len_sel == '0) ? LENW'(1) : len_sel;
  assign fire       = (fsm_q == RUN) && out_valid_q && bus.out_ready;

  // The displayed block holds lfsr^0..lfsr^(POLY-1) of the state, so one more step past
  // its last word is lfsr^POLY(state): the advance needs only a single extra stage.
  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_adv (
    .din  (out_data_q[POLY-1]),
    .dout (adv)
  );

  // Generator state: seeds land only in IDLE, advances only on a handshake.
  always_comb begin
    state_d = state_q;
    if (fsm_q == IDLE) begin
      if (bus.seed_load)    state_d = seed_fixed;
      else if (seed_pend_q) state_d = seed_val_q;
    end else if (fire) begin
      state_d = adv;
    end
  end

  // The next block to display is built from the next state, keeping out_data registered.
  for (genvar i = 0; i < POLY; i++) begin : g_word
    logic [WIDTH-1:0] w;
    if (i == 0) begin : g_head
      assign w = state_d;
    end else begin : g_step
      lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
        .din  (g_word[i-1].w),
        .dout (w)
      );
    end
    assign words[i] = w;
  end

  always_comb begin
    fsm_d       = fsm_q;
    ptr_d       = ptr_q;
    seed_pend_d = seed_pend_q;
    seed_val_d  = seed_val_q;
    len_d       = len_q;
    beat_d      = beat_q;
    req_ready_d = '0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    case (fsm_q)
      IDLE: begin
        if (bus.seed_load || seed_pend_q) begin
          // Seeding consumes this IDLE cycle; any grant waits one cycle.
          seed_pend_d = 1'b0;
        end else if (grant_any) begin
          req_ready_d = grant_oh;
          len_d       = len_eff;
          beat_d      = '0;
          out_id_d    = grant_idx;
          ptr_d       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
          out_valid_d = 1'b1;
          out_last_d  = (len_eff == LENW'(1));
          out_data_d  = words;
          busy_d      = 1'b1;
          fsm_d       = RUN;
        end
      end
      RUN: begin
        if (bus.seed_load) begin
          seed_pend_d = 1'b1;
          seed_val_d  = seed_fixed;
        end
        if (fire) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            fsm_d       = IDLE;
          end else begin
            beat_d      = beat_q + LENW'(1);
            // Next beat (beat_q+1) is last when beat_q+1 == len-1.
            out_last_d  = (LW1'(beat_q) + LW1'(2)) == LW1'(len_q);
            out_data_d  = words;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q       <= IDLE;
      state_q     <= SEED;
      ptr_q       <= '0;
      seed_pend_q <= 1'b0;
      seed_val_q  <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      req_ready_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      seed_pend_q <= seed_pend_d;
      seed_val_q  <= seed_val_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      req_ready_q <= req_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_lfsr_rr_server.sv
// tb/tb_lfsr_rr_server.sv - directed, table-driven bench for lfsr_rr_server
module tb_lfsr_rr_server;

  localparam int WIDTH = 16;
  localparam int POLY  = 4;
  localparam int NREQ  = 4;
  localparam int LENW  = 8;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  lfsr_rr_server_if #(.WIDTH(WIDTH), .POLY(POLY), .NREQ(NREQ), .LENW(LENW)) bus ();

  lfsr_rr_server #(.WIDTH(WIDTH), .POLY(POLY), .NREQ(NREQ), .LENW(LENW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [7:0]  len;
    int          g;
    bit          seed_en;
    logic [15:0] seed;
    bit          has_w0;
    logic [15:0] w0;
    bit          bp;
    bit          seed_run;
  } burst_t;

  burst_t      vec [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_state;

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [63:0] block_of(input logic [15:0] s);
    logic [63:0] r;
    logic [15:0] w;
    w = s;
    for (int i = 0; i < 4; i++) begin
      r[16*i +: 16] = w;
      w = lstep(w);
    end
    return r;
  endfunction

  function automatic logic [15:0] adv4(input logic [15:0] s);
    return lstep(lstep(lstep(lstep(s))));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    bus.req_valid  = '0;
    bus.req_len    = '0;
    bus.seed_load  = 1'b0;
    bus.seed_value = '0;
    bus.out_ready  = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_req_ready", 64'(bus.req_ready), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_out_last", 64'(bus.out_last), 0);
    chk("rst_out_id", 64'(bus.out_id), 0);
    chk("rst_out_data", bus.out_data, 0);
    m_state       = 16'hFFFF;
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_burst(input burst_t v);
    int          n, lat, b, cyc;
    bit          stalled;
    logic [63:0] hold_d;
    logic        hold_l;
    logic [1:0]  hold_id;
    n = (v.len == 0) ? 1 : int'(v.len);
    for (int i = 0; i < NREQ; i++) bus.req_len[i] = v.len;
    bus.req_valid = v.mask;
    if (v.seed_en) begin
      bus.seed_load  = 1'b1;
      bus.seed_value = v.seed;
      m_state        = (v.seed == 16'h0) ? 16'hFFFF : v.seed;
    end
    lat = 0;
    do begin
      tick();
      bus.seed_load = 1'b0;
      lat++;
    end while (bus.req_ready == 0 && lat < 10);
    chk("grant_latency", 64'(lat), v.seed_en ? 2 : 1);
    chk("grant_vector", 64'(bus.req_ready), 64'(1) << v.g);
    chk("busy_run", 64'(bus.busy), 1);
    bus.req_valid = '0;
    b = 0; cyc = 0; stalled = 0;
    hold_d = '0; hold_l = 1'b0; hold_id = '0;
    while (b < n && cyc < 2000) begin
      bus.out_ready  = v.bp ? (cyc % 3 == 0) : 1'b1;
      bus.seed_load  = v.seed_run && (cyc < 2);
      bus.seed_value = (cyc == 0) ? 16'h1234 : 16'hABCD;
      if (stalled) begin
        chk("stall_data", bus.out_data, hold_d);
        chk("stall_last", 64'(bus.out_last), 64'(hold_l));
        chk("stall_id", 64'(bus.out_id), 64'(hold_id));
      end
      stalled = 0;
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_data", bus.out_data, block_of(m_state));
        chk("beat_id", 64'(bus.out_id), 64'(v.g));
        chk("beat_last", 64'(bus.out_last), 64'(b == n - 1));
        if (b == 0 && v.has_w0) chk("word0", 64'(bus.out_data[0]), 64'(v.w0));
        m_state = adv4(m_state);
        b++;
      end else if (bus.out_valid) begin
        stalled = 1;
        hold_d  = bus.out_data;
        hold_l  = bus.out_last;
        hold_id = bus.out_id;
      end
      tick();
      cyc++;
    end
    bus.seed_load = 1'b0;
    bus.out_ready = 1'b1;
    chk("beat_count", 64'(b), 64'(n));
    chk("end_valid", 64'(bus.out_valid), 0);
    chk("end_busy", 64'(bus.busy), 0);
    if (v.seed_run) m_state = 16'hABCD;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int          k, cyc, last_t, hs;
    int          seq [9];
    burst_t      rb;

    //         mask     len     g  sd seed      w0? w0        bp run
    vec[0] = '{4'b0100, 8'd3,   2, 0, 16'h0000, 1, 16'hFFFF, 0, 0};
    vec[1] = '{4'b0001, 8'd4,   0, 0, 16'h0000, 0, 16'h0000, 1, 0};
    vec[2] = '{4'b0010, 8'd0,   1, 0, 16'h0000, 0, 16'h0000, 0, 0};
    vec[3] = '{4'b0010, 8'd2,   1, 1, 16'h0001, 1, 16'h0001, 0, 0};
    vec[4] = '{4'b1000, 8'd1,   3, 1, 16'h0000, 1, 16'hFFFF, 0, 0};
    vec[5] = '{4'b0100, 8'd3,   2, 0, 16'h0000, 0, 16'h0000, 0, 1};
    vec[6] = '{4'b0001, 8'd2,   0, 0, 16'h0000, 1, 16'hABCD, 0, 0};
    vec[7] = '{4'b1000, 8'd255, 3, 0, 16'h0000, 0, 16'h0000, 0, 0};
    seq = '{0, 1, 2, 3, 0, 2, 3, 0, 2};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      do_burst(vec[i]);
    end

    // Round-robin fairness with every requester asking for single-block bursts.
    do_reset();
    for (int i = 0; i < NREQ; i++) bus.req_len[i] = 8'd1;
    bus.req_valid = 4'b1111;
    k = 0; cyc = 0; last_t = 0;
    while (k < 9 && cyc < 200) begin
      tick();
      cyc++;
      if (bus.req_ready != 0) begin
        chk("rr_order", 64'(bus.req_ready), 64'(1) << seq[k]);
        if (k > 0) chk("rr_gap", 64'(cyc - last_t), 2);
        last_t = cyc;
        k++;
        if (k == 5) bus.req_valid = 4'b1101;
        if (k == 9) bus.req_valid = 4'b0000;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("rr_data", bus.out_data, block_of(m_state));
        m_state = adv4(m_state);
      end
    end
    chk("rr_grants", 64'(k), 9);
    tick();
    tick();

    // Reset during beat 2 of a 5-block burst.
    for (int i = 0; i < NREQ; i++) bus.req_len[i] = 8'd5;
    bus.req_valid = 4'b0001;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.req_ready == 0 && cyc < 10);
    chk("mid_grant", 64'(bus.req_ready), 64'b0001);
    bus.req_valid = '0;
    hs = 0; cyc = 0;
    while (hs < 2 && cyc < 20) begin
      if (bus.out_valid && bus.out_ready) begin
        chk("mid_data", bus.out_data, block_of(m_state));
        m_state = adv4(m_state);
        hs++;
      end
      tick();
      cyc++;
    end
    chk("mid_valid", 64'(bus.out_valid), 1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(bus.out_valid), 0);
    chk("mid_rst_busy", 64'(bus.busy), 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_id", 64'(bus.out_id), 0);
    chk("mid_rst_last", 64'(bus.out_last), 0);
    do_reset();
    // Pointer back at 0 picks requester 0 from {0,3}; a pointer left at 1 would pick 3.
    rb = '{4'b1001, 8'd2, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 0};
    do_burst(rb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
